// File: rtl/pc_sequencer.sv
// pc_sequencer: PIC16F instruction-cycle controller (Q1..Q4 phase, PC strobes, flush, ISR entry).
// Optional SLEEP support is compiled in when PC_SEQ_SLEEP_EN is defined.
`default_nettype none

module pc_sequencer #(
  parameter bit FIRST_CYCLE_FLUSH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_goto,
  input  logic       dec_call,
  input  logic       dec_return,
  input  logic       dec_retfie,
  input  logic       dec_skip_taken,
  input  logic       dec_pcl_write,
  input  logic       dec_sleep,
  input  logic       int_pending,
  input  logic       gie,
  output logic [1:0] q_phase,
  output logic       flush,
  output logic       ir_load_en,
  output logic       pc_incr_en,
  output logic       pc_j_en,
  output logic       pc_j_and_push_en,
  output logic       pc_j_by_pop_en,
  output logic       pc_j_to_isr,
  output logic       gie_clr,
  output logic       gie_set,
  output logic       sleeping
);

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_t;

  phase_t phase, phase_next;
  logic   flush_q, flush_next;
  logic   sleep_q, sleep_next;
  logic   transfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= Q1;
      flush_q <= FIRST_CYCLE_FLUSH;
      sleep_q <= 1'b0;
    end else begin
      phase   <= phase_next;
      flush_q <= flush_next;
      sleep_q <= sleep_next;
    end
  end

  always_comb begin
    phase_next       = phase_t'(phase + 2'd1);
    flush_next       = flush_q;
    sleep_next       = sleep_q;
    transfer         = 1'b0;
    ir_load_en       = 1'b0;
    pc_incr_en       = 1'b0;
    pc_j_en          = 1'b0;
    pc_j_and_push_en = 1'b0;
    pc_j_by_pop_en   = 1'b0;
    pc_j_to_isr      = 1'b0;
    gie_clr          = 1'b0;
    gie_set          = 1'b0;

    if (sleep_q) begin
      // Halted: hold Q1 and wake on any pending interrupt, enabled or not.
      phase_next = Q1;
      if (int_pending) sleep_next = 1'b0;
    end else if (phase == Q4) begin
      ir_load_en = 1'b1;
      if (flush_q) begin
        pc_incr_en = 1'b1;
      end else if (dec_goto) begin
        pc_j_en  = 1'b1;
        transfer = 1'b1;
      end else if (dec_call) begin
        pc_j_and_push_en = 1'b1;
        transfer         = 1'b1;
      end else if (dec_return) begin
        pc_j_by_pop_en = 1'b1;
        gie_set        = dec_retfie;
        transfer       = 1'b1;
      end else if (dec_pcl_write) begin
        transfer = 1'b1;
      end else if (gie && int_pending) begin
        // PC still addresses the prefetched (discarded) instruction: push it as return address.
        pc_j_to_isr = 1'b1;
        gie_clr     = 1'b1;
        transfer    = 1'b1;
      end else begin
        pc_incr_en = 1'b1;
`ifdef PC_SEQ_SLEEP_EN
        if (dec_sleep) sleep_next = 1'b1;
`endif
      end
      flush_next = transfer || (!flush_q && dec_skip_taken);
    end
  end

`ifndef PC_SEQ_SLEEP_EN
  logic unused_dec_sleep;
  assign unused_dec_sleep = dec_sleep;
`endif

  assign q_phase  = phase;
  assign flush    = flush_q;
  assign sleeping = sleep_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer against an instruction-cycle model.
`default_nettype none

module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_goto = 0, dec_call = 0, dec_return = 0, dec_retfie = 0;
  logic dec_skip_taken = 0, dec_pcl_write = 0, dec_sleep = 0;
  logic int_pending = 0, gie = 0;
  logic [1:0] q_phase;
  logic flush, ir_load_en, pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en;
  logic pc_j_to_isr, gie_clr, gie_set, sleeping;

  pc_sequencer #(.FIRST_CYCLE_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst),
    .dec_goto(dec_goto), .dec_call(dec_call), .dec_return(dec_return),
    .dec_retfie(dec_retfie), .dec_skip_taken(dec_skip_taken),
    .dec_pcl_write(dec_pcl_write), .dec_sleep(dec_sleep),
    .int_pending(int_pending), .gie(gie),
    .q_phase(q_phase), .flush(flush), .ir_load_en(ir_load_en),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_j_and_push_en(pc_j_and_push_en), .pc_j_by_pop_en(pc_j_by_pop_en),
    .pc_j_to_isr(pc_j_to_isr), .gie_clr(gie_clr), .gie_set(gie_set),
    .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  // {flush, incr, jump, call, pop, isr, gie_clr, gie_set, ir_load}
  typedef logic [8:0] exp_t;
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic m_flush;
  logic m_sleep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: any Q4 activity must match the oldest predicted instruction cycle.
  always @(negedge clk) begin
    if (!rst && (ir_load_en || pc_incr_en || pc_j_en || pc_j_and_push_en ||
                 pc_j_by_pop_en || pc_j_to_isr || gie_clr || gie_set)) begin
      check("strobe_phase", {30'd0, q_phase}, 32'd3);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q4_strobes",
              {23'd0, flush, pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
               pc_j_to_isr, gie_clr, gie_set, ir_load_en},
              {23'd0, e});
      end
    end
  end

  // Entered #1 after the edge that starts Q1; returns #1 after the edge starting the next Q1.
  task automatic issue(input logic go, input logic ca, input logic re, input logic rf,
                       input logic pw, input logic sk, input logic sl,
                       input logic ip, input logic ge);
    logic fl, incr, j, call, pop, isr, gc, gs, xfer;
    dec_goto = go; dec_call = ca; dec_return = re | rf; dec_retfie = rf;
    dec_pcl_write = pw; dec_skip_taken = sk; dec_sleep = sl;
    int_pending = ip; gie = ge;
    fl = m_flush;
    {incr, j, call, pop, isr, gc, gs} = '0;
    xfer = 1'b0;
    // Priority from the instruction-cycle rules: flush, GOTO, CALL, RETURN, PCL write, IRQ, else increment.
    if (fl)                    incr = 1'b1;
    else if (go)               begin j = 1'b1; xfer = 1'b1; end
    else if (ca)               begin call = 1'b1; xfer = 1'b1; end
    else if (re | rf)          begin pop = 1'b1; gs = rf; xfer = 1'b1; end
    else if (pw)               xfer = 1'b1;
    else if (ge && ip)         begin isr = 1'b1; gc = 1'b1; xfer = 1'b1; end
    else begin
      incr = 1'b1;
`ifdef PC_SEQ_SLEEP_EN
      m_sleep = sl;
`endif
    end
    sb.push_back({fl, incr, j, call, pop, isr, gc, gs, 1'b1});
    m_flush = xfer || (!fl && sk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    nop();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_flush = 1'b1;
    m_sleep = 1'b0;
    check("midrst_phase", {30'd0, q_phase}, 32'd0);
    check("midrst_flush", {31'd0, flush}, 32'd1);
    check("midrst_sleep", {31'd0, sleeping}, 32'd0);
  endtask

  initial begin
    m_flush = 1'b1;
    m_sleep = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", {30'd0, q_phase}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd1);
    check("rst_sleeping", {31'd0, sleeping}, 32'd0);
    check("rst_strobes", {23'd0, ir_load_en, pc_incr_en, pc_j_en, pc_j_and_push_en,
                          pc_j_by_pop_en, pc_j_to_isr, gie_clr, gie_set, 1'b0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First cycle is a flush, then straight-line code.
    nop(); nop(); nop(); nop();
    check("post_flush", {31'd0, flush}, 32'd0);
    // GOTO, then its flush, then normal.
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0); nop(); nop();
    // CALL then RETFIE.
    issue(0, 1, 0, 0, 0, 0, 0, 0, 0); nop(); nop();
    issue(0, 0, 1, 1, 0, 0, 0, 0, 0); nop(); nop();
    // Interrupt raised during a GOTO: deferred past the flush cycle.
    issue(1, 0, 0, 0, 0, 0, 0, 1, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(); nop();
    // Taken skip and PCL write each flush the following cycle.
    issue(0, 0, 0, 0, 0, 1, 0, 0, 0); nop();
    issue(0, 0, 0, 0, 1, 0, 0, 1, 1); nop();

`ifdef PC_SEQ_SLEEP_EN
    issue(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("sleep_model", {31'd0, m_sleep}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("sleep_state", {29'd0, sleeping, q_phase}, 32'h4);
      @(posedge clk); #1;
    end
    int_pending = 1'b1; gie = 1'b0;
    @(posedge clk); #1;
    m_sleep = 1'b0;
    check("wake_state", {29'd0, sleeping, q_phase}, 32'h0);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop();
`else
    issue(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("sleep_ignored", {31'd0, sleeping}, 32'd0);
`endif

    mid_reset();
    nop(); nop();

    for (int n = 0; n < 250; n++) begin
      logic go, ca, re, rf, pw, sk, sl, ip, ge;
      go = ($urandom_range(0, 99) < 12);
      ca = ($urandom_range(0, 99) < 10);
      re = ($urandom_range(0, 99) < 10);
      rf = re && ($urandom_range(0, 1) == 1);
      pw = ($urandom_range(0, 99) < 8);
      sk = ($urandom_range(0, 99) < 15);
      ip = ($urandom_range(0, 99) < 25);
      ge = ($urandom_range(0, 1) == 1);
`ifdef PC_SEQ_SLEEP_EN
      sl = 1'b0;
`else
      sl = ($urandom_range(0, 99) < 10);
`endif
      issue(go, ca, re, rf, pw, sk, sl, ip, ge);
      if (n == 120) mid_reset();
    end

    nop();
    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
